// File: rtl/key_event_pkg.sv
// Shared types and helpers for the key event generator.
// Build option: KEY_AUTO_REPEAT_EN enables auto-repeat while held.
package key_event_pkg;

  typedef enum logic [1:0] {
    KEY_IDLE,
    KEY_PRESS,
    KEY_LONG
  } key_state_t;

  localparam int MS_PER_S = 1000;

  function automatic int tick_div(input int clk_hz);
    int div;
    div = clk_hz / MS_PER_S;
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running 1 ms tick from a clk prescaler.
// Tick is high for the single cycle at terminal count.
module ms_tick_gen
  import key_event_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int DIV = tick_div(CLK_HZ);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // prescaler wraps at terminal count, never cleared otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/key_event_gen.sv
// Debounced key level to one-cycle press/release/short/long events.
// Build option: KEY_AUTO_REPEAT_EN adds repeat_pulse while in LONG.
module key_event_gen
  import key_event_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200,
  parameter int CNT_W     = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic key_level,
  input  logic enable,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic key_held
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_MS - 1);

  logic             tick;
  logic             key_q;
  logic             rise;
  logic             fall;
  logic             at_long;
  logic [CNT_W-1:0] hold_cnt;
  key_state_t       state;
  key_state_t       state_nx;
  logic             press_nx;
  logic             release_nx;
  logic             short_nx;
  logic             long_nx;
  logic             repeat_nx;

  ms_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign rise    = key_level & ~key_q;
  assign fall    = ~key_level & key_q;
  assign at_long = tick & (hold_cnt == HOLD_LAST);

  // previous level; preset so a key held through reset is not a press
  always_ff @(posedge clk or posedge reset) begin
    if (reset) key_q <= 1'b1;
    else       key_q <= key_level;
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= KEY_IDLE;
    else       state <= state_nx;
  end

  // next state; disable forces IDLE
  always_comb begin
    state_nx = state;
    if (!enable) begin
      state_nx = KEY_IDLE;
    end else begin
      unique case (state)
        KEY_IDLE:  if (rise) state_nx = KEY_PRESS;
        KEY_PRESS: begin
          if (fall)         state_nx = KEY_IDLE;
          else if (at_long) state_nx = KEY_LONG;
        end
        KEY_LONG:  if (fall) state_nx = KEY_IDLE;
        default:   state_nx = KEY_IDLE;
      endcase
    end
  end

  // pulse conditions; a fall always beats the long threshold
  always_comb begin
    press_nx   = 1'b0;
    release_nx = 1'b0;
    short_nx   = 1'b0;
    long_nx    = 1'b0;
    if (enable) begin
      unique case (state)
        KEY_IDLE:  press_nx = rise;
        KEY_PRESS: begin
          release_nx = fall;
          short_nx   = fall;
          long_nx    = ~fall & at_long;
        end
        KEY_LONG:  release_nx = fall;
        default:   ;
      endcase
    end
  end

  // hold time in ms ticks, saturating
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (press_nx) begin
      hold_cnt <= '0;
    end else if (state == KEY_PRESS && tick &&
                 hold_cnt != '1) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

`ifdef KEY_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST =
    CNT_W'(REPEAT_MS - 1);

  logic [CNT_W-1:0] rep_cnt;

  assign repeat_nx = enable & (state == KEY_LONG) &
                     ~fall & tick & (rep_cnt == REP_LAST);

  // repeat period counter, restarted on long press
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt <= '0;
    end else if (long_nx) begin
      rep_cnt <= '0;
    end else if (state == KEY_LONG && tick) begin
      if (rep_cnt == REP_LAST)  rep_cnt <= '0;
      else if (rep_cnt != '1)   rep_cnt <= rep_cnt + 1'b1;
    end
  end
`else
  logic unused_repeat_ms;
  assign unused_repeat_ms = ^REPEAT_MS;
  assign repeat_nx = 1'b0;
`endif

  // registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      key_held      <= 1'b0;
    end else begin
      press_pulse   <= press_nx;
      release_pulse <= release_nx;
      short_pulse   <= short_nx;
      long_pulse    <= long_nx;
      repeat_pulse  <= repeat_nx;
      key_held      <= (state_nx != KEY_IDLE);
    end
  end

endmodule

// File: tb/tb_key_event_gen.sv
// Directed self-checking bench for key_event_gen.
// Tick every 10 cycles, LONG_MS=5, REPEAT_MS=2.
module tb_key_event_gen;

`ifdef KEY_AUTO_REPEAT_EN
  localparam int REP = 1;
`else
  localparam int REP = 0;
`endif

  logic clk;
  logic reset;
  logic key_level;
  logic enable;
  logic press_pulse;
  logic release_pulse;
  logic short_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic key_held;

  int total;
  int bad;
  int cyc;
  int n_press, n_rel, n_short, n_long, n_rep;
  int p0, r0, s0, l0, q0;

  key_event_gen #(
    .CLK_HZ   (10_000),
    .LONG_MS  (5),
    .REPEAT_MS(2),
    .CNT_W    (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_level    (key_level),
    .enable       (enable),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .key_held     (key_held)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // edges since reset release, mirrors prescaler phase
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (press_pulse)   n_press <= n_press + 1;
    if (release_pulse) n_rel   <= n_rel + 1;
    if (short_pulse)   n_short <= n_short + 1;
    if (long_pulse)    n_long  <= n_long + 1;
    if (repeat_pulse)  n_rep   <= n_rep + 1;
  end

  initial begin
    n_press = 0;
    n_rel   = 0;
    n_short = 0;
    n_long  = 0;
    n_rep   = 0;
  end

  task automatic chk(input string tag, input int obs,
                     input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic align(input int p);
    int guard;
    guard = 0;
    while ((cyc % 10) != p && guard < 20) begin
      step(1);
      guard++;
    end
    chk("align", cyc % 10, p);
  endtask

  task automatic snap();
    p0 = n_press;
    r0 = n_rel;
    s0 = n_short;
    l0 = n_long;
    q0 = n_rep;
  endtask

  function automatic int outs();
    return {26'd0, press_pulse, release_pulse,
            short_pulse, long_pulse, repeat_pulse,
            key_held};
  endfunction

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    key_level = 1'b1;
    enable    = 1'b1;

    // 1: key held through reset
    step(3);
    chk("reset_outs", outs(), 0);
    reset = 1'b0;
    snap();
    step(100);
    chk("t1_no_press", n_press - p0, 0);
    chk("t1_held", key_held, 0);
    key_level = 1'b0;
    step(3);
    chk("t1_no_release", n_rel - r0, 0);
    chk("t1_no_short", n_short - s0, 0);

    // 2: short press
    snap();
    key_level = 1'b1;
    step(1);
    chk("t2_press", press_pulse, 1);
    chk("t2_held", key_held, 1);
    step(1);
    chk("t2_press_1cyc", press_pulse, 0);
    step(18);
    key_level = 1'b0;
    step(1);
    chk("t2_rel_short", {release_pulse, short_pulse}, 3);
    chk("t2_held_off", key_held, 0);
    step(1);
    chk("t2_rel_1cyc", {release_pulse, short_pulse}, 0);
    chk("t2_n_press", n_press - p0, 1);
    chk("t2_no_long", n_long - l0, 0);

    // 3: long press with optional repeat
    step(3);
    align(0);
    snap();
    key_level = 1'b1;
    step(49);
    chk("t3_long_early", long_pulse, 0);
    step(1);
    chk("t3_long", long_pulse, 1);
    chk("t3_held", key_held, 1);
    step(1);
    chk("t3_long_1cyc", long_pulse, 0);
    step(18);
    chk("t3_rep_early", repeat_pulse, 0);
    step(1);
    chk("t3_rep_first", repeat_pulse, REP);
    step(1);
    chk("t3_rep_1cyc", repeat_pulse, 0);
    step(129);
    key_level = 1'b0;
    step(1);
    chk("t3_release", release_pulse, 1);
    chk("t3_no_short", short_pulse, 0);
    step(1);
    chk("t3_n_long", n_long - l0, 1);
    chk("t3_n_rep", n_rep - q0, 7 * REP);
    chk("t3_n_rel", n_rel - r0, 1);
    chk("t3_n_short", n_short - s0, 0);

    // 4: fall on the 5th tick wins over long
    step(3);
    align(0);
    snap();
    key_level = 1'b1;
    step(49);
    key_level = 1'b0;
    step(1);
    chk("t4_rel_short", {release_pulse, short_pulse}, 3);
    chk("t4_no_long", long_pulse, 0);
    step(5);
    chk("t4_n_long", n_long - l0, 0);

    // 5: enable dropped in LONG
    step(3);
    align(0);
    key_level = 1'b1;
    step(60);
    chk("t5_held_long", key_held, 1);
    snap();
    enable = 1'b0;
    step(1);
    chk("t5_held_off", key_held, 0);
    step(30);
    chk("t5_quiet",
        (n_press - p0) + (n_rel - r0) + (n_short - s0) +
        (n_long - l0) + (n_rep - q0), 0);
    enable = 1'b1;
    step(30);
    chk("t5_no_press", n_press - p0, 0);
    chk("t5_still_idle", key_held, 0);
    key_level = 1'b0;
    step(3);
    key_level = 1'b1;
    step(1);
    chk("t5_repress", press_pulse, 1);
    key_level = 1'b0;
    step(1);
    chk("t5_rel_short", {release_pulse, short_pulse}, 3);

    // 6: async reset mid-PRESS
    step(3);
    key_level = 1'b1;
    step(5);
    chk("t6_held", key_held, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_outs", outs(), 0);
    step(2);
    reset = 1'b0;
    snap();
    step(100);
    chk("t6_quiet",
        (n_press - p0) + (n_rel - r0) + (n_short - s0) +
        (n_long - l0) + (n_rep - q0), 0);
    chk("t6_held_off", key_held, 0);
    key_level = 1'b0;
    step(3);
    chk("t6_no_release", n_rel - r0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
